spike_id_fifo: RTL

SPIKE_ID_FIFO -- requirements
Module: spike_id_fifo

---
 rtl/spike_id_fifo_pkg.sv | 39 +++
 rtl/gray_ptr_sync.sv | 40 ++++
 rtl/spike_id_fifo.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spike_id_fifo_pkg.sv
// Shared word encodings for the spike-event FIFO: spike and frame-marker formats,
// the value returned on an empty read, and the write-source selector.
`timescale 1ns/1ps
package spike_id_fifo_pkg;

  localparam int WORD_W     = 16;
  localparam int ID_W       = 15;
  localparam int MARKER_BIT = 15;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ID_W-1:0]   id_t;

  localparam word_t EMPTY_WORD = 16'h0000;

  // Which candidate owns the single write slot of a clk1 cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MARKER,
    SRC_PEND,
    SRC_SPIKE
  } wr_src_e;

  function automatic word_t spike_word(input id_t id);
    word_t w;
    w             = '0;
    w[ID_W-1:0]   = id;
    w[MARKER_BIT] = 1'b0;
    return w;
  endfunction

  function automatic word_t marker_word(input id_t frame);
    word_t w;
    w             = '0;
    w[ID_W-1:0]   = frame;
    w[MARKER_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Carries a binary FIFO pointer across clock domains: registered Gray code in the source
// domain, 2-flop synchronizer in the destination domain, decoded back to binary there.
`timescale 1ns/1ps
module gray_ptr_sync #(
  parameter int W = 11
) (
  input  logic         src_clk,
  input  logic         src_rst,
  input  logic [W-1:0] src_bin_nxt,
  input  logic         dst_clk,
  input  logic         dst_rst,
  output logic [W-1:0] dst_bin
);

  logic [W-1:0] src_gray;
  logic [W-1:0] sync_ff1;
  logic [W-1:0] sync_ff2;

  // Fed with the next pointer so the Gray register moves on the same edge as the pointer.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) src_gray <= '0;
    else         src_gray <= src_bin_nxt ^ (src_bin_nxt >> 1);
  end

  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
    end else begin
      sync_ff1 <= src_gray;
      sync_ff2 <= sync_ff1;
    end
  end

  always_comb begin
    dst_bin = '0;
    for (int i = 0; i < W; i++) dst_bin[i] = ^(sync_ff2 >> i);
  end

endmodule

// File: rtl/spike_id_fifo.sv
// Spike/frame-marker async FIFO from the neuron pool (clk1) to the host pipe (ti_clk); pop latency 1.
// No backpressure on the write side: words that find the FIFO full or the pending slot busy are counted and dropped.
`timescale 1ns/1ps
module spike_id_fifo
  import spike_id_fifo_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic        clk1,
  input  logic        ti_clk,
  input  logic        reset_global,
  input  logic        spike_valid,
  input  logic [14:0] spike_id,
  input  logic        sim_tick,
  input  logic        ep_read,
  output logic [15:0] ep_dataout,
  output logic        ep_ready,
  output logic [15:0] overflow_cnt,
  output logic        underrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] BLOCK_LV = PTR_W'(BLOCK_WORDS);

  // Per-domain reset: asserts immediately, releases two local edges later.
  logic [1:0] rst1_sr;
  logic [1:0] rstt_sr;
  logic       rst1;
  logic       rst_t;

  always_ff @(posedge clk1 or posedge reset_global) begin
    if (reset_global) rst1_sr <= 2'b11;
    else              rst1_sr <= {rst1_sr[0], 1'b0};
  end

  always_ff @(posedge ti_clk or posedge reset_global) begin
    if (reset_global) rstt_sr <= 2'b11;
    else              rstt_sr <= {rstt_sr[0], 1'b0};
  end

  assign rst1  = rst1_sr[1];
  assign rst_t = rstt_sr[1];

  word_t mem [DEPTH];

  logic [PTR_W-1:0] wptr, wptr_nxt, rsync;
  logic [PTR_W-1:0] rptr, rptr_nxt, wsync;
  logic             pend_vld;
  id_t              pend_id;
  id_t              frame_cnt;
  wr_src_e          wr_src;
  word_t            wr_word;
  logic             full, wr_try, wr_ok, full_drop, pend_load, pend_drop;
  logic [16:0]      ovf_sum;
  logic             empty, pop;

  // Marker wins the slot, then a held spike, then a fresh spike.
  always_comb begin
    wr_src  = SRC_NONE;
    wr_word = EMPTY_WORD;
    if (sim_tick) begin
      wr_src  = SRC_MARKER;
      wr_word = marker_word(frame_cnt);
    end else if (pend_vld) begin
      wr_src  = SRC_PEND;
      wr_word = spike_word(pend_id);
    end else if (spike_valid) begin
      wr_src  = SRC_SPIKE;
      wr_word = spike_word(spike_id);
    end
  end

  assign full      = (wptr[ADDR_W] != rsync[ADDR_W]) &&
                     (wptr[ADDR_W-1:0] == rsync[ADDR_W-1:0]);
  assign wr_try    = (wr_src != SRC_NONE);
  assign wr_ok     = wr_try && !full;
  assign full_drop = wr_try && full;
  assign pend_load = sim_tick && spike_valid && !pend_vld;
  assign pend_drop = spike_valid && pend_vld;
  assign wptr_nxt  = wptr + PTR_W'(wr_ok);
  assign ovf_sum   = {1'b0, overflow_cnt} + 17'(full_drop) + 17'(pend_drop);

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      wptr         <= '0;
      pend_vld     <= 1'b0;
      pend_id      <= '0;
      frame_cnt    <= '0;
      overflow_cnt <= '0;
    end else begin
      wptr <= wptr_nxt;
      if (sim_tick) frame_cnt <= frame_cnt + 15'd1;
      if (pend_load) begin
        pend_vld <= 1'b1;
        pend_id  <= spike_id;
      end else if (wr_src == SRC_PEND) begin
        pend_vld <= 1'b0;
      end
      overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end

  always_ff @(posedge clk1) begin
    if (wr_ok) mem[wptr[ADDR_W-1:0]] <= wr_word;
  end

  gray_ptr_sync #(.W(PTR_W)) u_wptr_sync (
    .src_clk     (clk1),
    .src_rst     (rst1),
    .src_bin_nxt (wptr_nxt),
    .dst_clk     (ti_clk),
    .dst_rst     (rst_t),
    .dst_bin     (wsync)
  );

  gray_ptr_sync #(.W(PTR_W)) u_rptr_sync (
    .src_clk     (ti_clk),
    .src_rst     (rst_t),
    .src_bin_nxt (rptr_nxt),
    .dst_clk     (clk1),
    .dst_rst     (rst1),
    .dst_bin     (rsync)
  );

  assign empty    = (rptr == wsync);
  assign pop      = ep_read && !empty;
  assign rptr_nxt = rptr + PTR_W'(pop);

  always_ff @(posedge ti_clk or posedge rst_t) begin
    if (rst_t) begin
      rptr       <= '0;
      ep_dataout <= EMPTY_WORD;
      ep_ready   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      rptr <= rptr_nxt;
      if (pop)          ep_dataout <= mem[rptr[ADDR_W-1:0]];
      else if (ep_read) ep_dataout <= EMPTY_WORD;
      // Uses the post-pop pointer so ready drops on the same edge as the pop that breaks the block.
      ep_ready <= ((wsync - rptr_nxt) >= BLOCK_LV);
      if (ep_read && empty) underrun <= 1'b1;
    end
  end

endmodule
